// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Booth pair is {Q[0], q_1}; all other pairs leave the accumulator alone.
  localparam logic [1:0] PAIR_ADD = 2'b01;
  localparam logic [1:0] PAIR_SUB = 2'b10;

  function automatic int steps(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: add/sub M, then arithmetic shift right.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] acc_i,
  input  logic [WIDTH:0] mul_i,
  input  logic           qm1_i,
  input  logic [WIDTH:0] mcand_i,
  output logic [WIDTH:0] acc_o,
  output logic [WIDTH:0] mul_o,
  output logic           qm1_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = acc_i;
    case ({mul_i[0], qm1_i})
      PAIR_ADD: sum = acc_i + mcand_i;
      PAIR_SUB: sum = acc_i - mcand_i;
      default:  sum = acc_i;
    endcase
  end

  // Shift of {A,Q,q_1} keeps the sign of A and moves A's LSB into Q's MSB.
  assign acc_o = {sum[WIDTH], sum[WIDTH:1]};
  assign mul_o = {sum[0], mul_i[WIDTH:1]};
  assign qm1_o = mul_i[0];

endmodule

// File: rtl/seq_booth_multiplier.sv
// Multi-cycle radix-2 Booth multiplier with start/done handshake and signed/unsigned mode.
// Optional product accumulation is enabled by defining SEQ_BOOTH_ACC_EN.
module seq_booth_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
`ifdef SEQ_BOOTH_ACC_EN
  input  logic                 accumulate,
`endif
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int STEPS = steps(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  state_e             state_q;
  logic [WIDTH:0]     acc_q, mul_q, mcand_q;
  logic               qm1_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q, done_q;
  logic [2*WIDTH-1:0] product_q;
`ifdef SEQ_BOOTH_ACC_EN
  logic               accEn_q;
`endif

  logic [WIDTH:0]     acc_d, mul_d;
  logic               qm1_d;
  logic [2*WIDTH-1:0] result;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .mul_i   (mul_q),
    .qm1_i   (qm1_q),
    .mcand_i (mcand_q),
    .acc_o   (acc_d),
    .mul_o   (mul_d),
    .qm1_o   (qm1_d)
  );

  // The top two bits of {A,Q} are pure sign extension, so truncation is exact.
  assign result = (2*WIDTH)'({acc_d, mul_d});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mul_q     <= '0;
      mcand_q   <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
`ifdef SEQ_BOOTH_ACC_EN
      accEn_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
          if (start) begin
            mcand_q <= is_signed ? {a[WIDTH-1], a} : {1'b0, a};
            mul_q   <= is_signed ? {b[WIDTH-1], b} : {1'b0, b};
            acc_q   <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef SEQ_BOOTH_ACC_EN
            accEn_q <= accumulate;
`endif
          end
        end
        RUN: begin
          acc_q <= acc_d;
          mul_q <= mul_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
`ifdef SEQ_BOOTH_ACC_EN
            product_q <= accEn_q ? (product_q + result) : result;
`else
            product_q <= result;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Scoreboard-based bench for seq_booth_multiplier at WIDTH=4 (accumulate tests under SEQ_BOOTH_ACC_EN).
module tb_seq_booth_multiplier;

  localparam int W = 4;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    logic [7:0] p;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic         accumulate;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [2*W-1:0] product;

  int nChecks = 0;
  int nFails  = 0;
  logic [7:0] expQ [$];

  always #5 clk = ~clk;

  seq_booth_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
`ifdef SEQ_BOOTH_ACC_EN
    .accumulate(accumulate),
`endif
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  // Behavioural reference: full-precision integer multiply, truncated to 2*W bits.
  function automatic logic [7:0] refMul(input logic [3:0] x, input logic [3:0] y, input logic s);
    int xi, yi, p;
    xi = s ? int'($signed(x)) : int'(x);
    yi = s ? int'($signed(y)) : int'(y);
    p  = xi * yi;
    return 8'(p);
  endfunction

  // Drives one operation and waits (bounded) for done; index 0 is the negedge after capture.
  task automatic run_op(input logic [3:0] ia, input logic [3:0] ib, input logic isS, input logic iAcc,
                        output logic [7:0] prod, output int lat, output int busyCnt, output bit timedOut);
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; is_signed = isS; accumulate = iAcc;
    @(negedge clk);
    start = 1'b0; a = ~ia; b = ~ib; is_signed = ~isS; accumulate = ~iAcc;
    lat = 0; busyCnt = 0; timedOut = 1'b1; prod = '0;
    if (busy) busyCnt++;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i; prod = product; timedOut = 1'b0;
        break;
      end
      if (busy) busyCnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; accumulate = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    nChecks++;
    if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    nChecks++;
    if (done !== 1'b0) begin nFails++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    nChecks++;
    if (product !== 8'h00) begin nFails++; $display("[TB] FAIL reset_product: got %h expected 00", product); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    vec_t tbl [5];
    logic [7:0] prod, exp;
    int lat, bc;
    bit to;
    tbl = '{'{4'd3, 4'hC, 1'b1, 8'hF4}, '{4'd3, 4'hC, 1'b0, 8'd36},
            '{4'hF, 4'hF, 1'b0, 8'd225}, '{4'hF, 4'hF, 1'b1, 8'd1},
            '{4'h8, 4'h8, 1'b1, 8'd64}};
    foreach (tbl[k]) begin
      expQ.push_back(tbl[k].p);
      run_op(tbl[k].a, tbl[k].b, tbl[k].s, 1'b0, prod, lat, bc, to);
      exp = expQ.pop_front();
      nChecks++;
      if (to) begin nFails++; $display("[TB] FAIL directed_timeout: no done for a=%h b=%h", tbl[k].a, tbl[k].b); end
      nChecks++;
      if (prod !== exp) begin nFails++; $display("[TB] FAIL directed_product a=%h b=%h s=%b: got %h expected %h", tbl[k].a, tbl[k].b, tbl[k].s, prod, exp); end
      nChecks++;
      if (lat !== 5) begin nFails++; $display("[TB] FAIL directed_latency: got %0d expected 5", lat); end
      nChecks++;
      if (bc !== 5) begin nFails++; $display("[TB] FAIL directed_busy_cycles: got %0d expected 5", bc); end
    end
  endtask

  task automatic test_sweep();
    logic [3:0] sa [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd2};
    logic [3:0] sb [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    logic [7:0] prod, exp;
    int lat, bc;
    bit to;
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 7; k++) begin
        expQ.push_back(8'(int'(sa[k]) * int'(sb[k])));
        run_op(sa[k], sb[k], m[0], 1'b0, prod, lat, bc, to);
        exp = expQ.pop_front();
        nChecks++;
        if (to || prod !== exp) begin nFails++; $display("[TB] FAIL sweep_product a=%0d b=%0d s=%0d: got %h expected %h", sa[k], sb[k], m, prod, exp); end
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [7:0] prod, exp;
    logic [3:0] x, y;
    logic s;
    int lat, bc;
    bit to;
    for (int i = 0; i < 256; i++) begin
      for (int m = 0; m < 2; m++) begin
        x = i[7:4]; y = i[3:0];
        s = m[0] ^ $urandom_range(0, 1) == 1;
        expQ.push_back(refMul(x, y, s));
        run_op(x, y, s, 1'b0, prod, lat, bc, to);
        exp = expQ.pop_front();
        nChecks++;
        if (to || prod !== exp) begin nFails++; $display("[TB] FAIL exhaustive_product a=%h b=%h s=%b: got %h expected %h", x, y, s, prod, exp); end
      end
    end
  endtask

  task automatic test_start_during_run();
    logic [7:0] prod, exp;
    int lat, bc;
    bit to;
    expQ.push_back(8'd15);
    @(negedge clk);
    start = 1'b1; a = 4'd5; b = 4'd3; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0; bc = busy ? 1 : 0;
    @(negedge clk);
    start = 1'b1; a = 4'd7; b = 4'd7; is_signed = 1'b1;
    if (busy) bc++;
    @(negedge clk);
    start = 1'b0;
    if (busy) bc++;
    lat = 0; to = 1'b1; prod = '0;
    for (int i = 3; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin lat = i; prod = product; to = 1'b0; break; end
      if (busy) bc++;
    end
    exp = expQ.pop_front();
    nChecks++;
    if (to || prod !== exp) begin nFails++; $display("[TB] FAIL ignore_start_product: got %h expected %h", prod, exp); end
    nChecks++;
    if (lat !== 5) begin nFails++; $display("[TB] FAIL ignore_start_latency: got %0d expected 5", lat); end
    nChecks++;
    if (bc !== 5) begin nFails++; $display("[TB] FAIL ignore_start_busy_cycles: got %0d expected 5", bc); end
    repeat (2) @(negedge clk);
    nChecks++;
    if (busy !== 1'b0 || done !== 1'b0) begin nFails++; $display("[TB] FAIL ignore_start_not_queued: busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] prod, exp;
    int lat, bc;
    bit to;
    expQ.push_back(refMul(4'd3, 4'd5, 1'b1));
    run_op(4'd3, 4'd5, 1'b1, 1'b0, prod, lat, bc, to);
    exp = expQ.pop_front();
    nChecks++;
    if (to || prod !== exp) begin nFails++; $display("[TB] FAIL b2b_first_product: got %h expected %h", prod, exp); end
    // Still in the DONE cycle here: raise start so it is accepted at the next edge.
    start = 1'b1; a = 4'd2; b = 4'hA; is_signed = 1'b1;
    expQ.push_back(8'hF4);
    @(negedge clk);
    start = 1'b0;
    nChecks++;
    if (busy !== 1'b1 || done !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_accept: busy=%b done=%b expected 1 0", busy, done); end
    lat = 0; to = 1'b1; prod = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin lat = i; prod = product; to = 1'b0; break; end
    end
    exp = expQ.pop_front();
    nChecks++;
    if (to || prod !== exp) begin nFails++; $display("[TB] FAIL b2b_second_product: got %h expected %h", prod, exp); end
    nChecks++;
    if (lat !== 5) begin nFails++; $display("[TB] FAIL b2b_latency: got %0d expected 5", lat); end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] prod, exp;
    int lat, bc;
    bit to, seenDone;
    @(negedge clk);
    start = 1'b1; a = 4'd3; b = 4'd3; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    nChecks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
      nFails++; $display("[TB] FAIL midrun_reset_outputs: busy=%b done=%b product=%h expected 0 0 00", busy, done, product);
    end
    @(negedge clk);
    rst = 1'b0;
    seenDone = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) seenDone = 1'b1;
    end
    nChecks++;
    if (seenDone !== 1'b0) begin nFails++; $display("[TB] FAIL midrun_reset_no_done: got done pulse expected none"); end
    expQ.push_back(8'd42);
    run_op(4'd6, 4'd7, 1'b0, 1'b0, prod, lat, bc, to);
    exp = expQ.pop_front();
    nChecks++;
    if (to || prod !== exp) begin nFails++; $display("[TB] FAIL midrun_reset_recover: got %h expected %h", prod, exp); end
  endtask

`ifdef SEQ_BOOTH_ACC_EN
  task automatic test_accumulate();
    vec_t tbl [5];
    logic accs [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] prod, exp;
    int lat, bc;
    bit to;
    tbl = '{'{4'd3, 4'd4, 1'b0, 8'd12}, '{4'd2, 4'd6, 1'b0, 8'd24},
            '{4'hF, 4'd1, 1'b1, 8'd23}, '{4'hF, 4'hF, 1'b0, 8'd248},
            '{4'hF, 4'hF, 1'b0, 8'd217}};
    foreach (tbl[k]) begin
      expQ.push_back(tbl[k].p);
      run_op(tbl[k].a, tbl[k].b, tbl[k].s, accs[k], prod, lat, bc, to);
      exp = expQ.pop_front();
      nChecks++;
      if (to || prod !== exp) begin nFails++; $display("[TB] FAIL accumulate_step%0d: got %h expected %h", k, prod, exp); end
      nChecks++;
      if (lat !== 5) begin nFails++; $display("[TB] FAIL accumulate_latency: got %0d expected 5", lat); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_sweep();
    test_exhaustive();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SEQ_BOOTH_ACC_EN
    test_accumulate();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
